// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t   : controller FSM states (RUN, MEMWAIT, ERR)
//   FWD_*     : EX-stage operand forwarding select codes
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// fwd_unit: combinational EX-stage forwarding select.
// Ports:
//   ex_rs, ex_rt              : source registers of the EX instruction
//   mem_A3, mem_RegWrite      : destination / write flag of the MEM instruction
//   wb_A3, wb_RegWrite        : destination / write flag of the WB instruction
//   fwd_a, fwd_b              : select for operand A (rs) and B (rt)
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_A3,
    input  logic       mem_RegWrite,
    input  logic [4:0] wb_A3,
    input  logic       wb_RegWrite,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // EX/MEM holds the newer value, so it wins over MEM/WB. $0 is hardwired
    // to zero and must never be forwarded.
    function automatic logic [1:0] sel(input logic [4:0] src,
                                       input logic [4:0] m_a3, input logic m_we,
                                       input logic [4:0] w_a3, input logic w_we);
        logic [1:0] r;
        r = FWD_RF;
        if (m_we && (m_a3 != 5'd0) && (m_a3 == src))
            r = FWD_MEM;
        else if (w_we && (w_a3 != 5'd0) && (w_a3 == src))
            r = FWD_WB;
        return r;
    endfunction

    assign fwd_a = sel(ex_rs, mem_A3, mem_RegWrite, wb_A3, wb_RegWrite);
    assign fwd_b = sel(ex_rt, mem_A3, mem_RegWrite, wb_A3, wb_RegWrite);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / flush / forwarding controller for a 5-stage
// MIPS pipeline, with a data-memory wait watchdog and a stall-cycle counter.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   id_*                              : ID-stage source regs and usage flags
//   ex_*                              : EX-stage regs, write/load flags, branch taken
//   mem_A3, mem_RegWrite, mem_req     : MEM-stage destination, write flag, dmem request
//   dmem_ready                        : data memory completes the access this cycle
//   wb_A3, wb_RegWrite                : WB-stage destination and write flag
//   pc_en .. memwb_en                 : pipeline register load enables
//   ifid_flush, idex_flush, memwb_flush : load a bubble into that register
//   fwd_a, fwd_b                      : EX operand forwarding selects
//   dmem_err                          : sticky watchdog error
//   stall_cnt                         : saturating count of cycles with pc_en=0
//   dbg_state                         : current FSM state (RUN/MEMWAIT/ERR encoding)
//
// Handshake: the MEM stage presents a request with mem_req (valid); the access
// completes in the cycle dmem_ready (ready) is also high. A cycle with
// mem_req=1 and dmem_ready=0 holds the pipeline; a cycle with both high
// completes without any stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_A3,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_A3,
    input  logic             mem_RegWrite,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_A3,
    input  logic             wb_RegWrite,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          memstall, loaduse;
    logic [1:0]    fwd_a_raw, fwd_b_raw;

    // ex_RegWrite is part of the EX-stage view but a load always writes, so
    // the hazard test keys on ex_MemRead alone.
    logic unused_ex_regwrite;
    assign unused_ex_regwrite = ex_RegWrite;

    assign memstall = mem_req & ~dmem_ready;
    assign loaduse  = ex_MemRead & (ex_A3 != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_A3)) |
                       (id_uses_rt & (id_rt == ex_A3)));

    fwd_unit u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_A3       (mem_A3),
        .mem_RegWrite (mem_RegWrite),
        .wb_A3        (wb_A3),
        .wb_RegWrite  (wb_RegWrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    assign fwd_a     = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b     = rst ? FWD_RF : fwd_b_raw;
    assign dmem_err  = (state == ERR) & ~rst;
    assign dbg_state = state;

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;

        if (rst) begin
            state_nxt = RUN;
            wait_nxt  = '0;
        end else if (state == ERR) begin
            state_nxt = ERR;
        end else if (memstall) begin
            // Upstream holds; WB retires and a bubble enters MEM/WB.
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            if (state == RUN) begin
                state_nxt = MEMWAIT;
                wait_nxt  = '0;
            end else if (wait_cnt == WW'(WAIT_MAX)) begin
                state_nxt = ERR;
            end else begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end else begin
            state_nxt = RUN;
            wait_nxt  = '0;
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            if (ex_branch_taken) begin
                // The ID instruction is squashed, so a load-use hazard on it is moot.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loaduse) begin
                // Hold PC and IF/ID one cycle, insert one bubble into ID/EX.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_A3, mem_A3, wb_A3;
  logic id_uses_rs, id_uses_rt, ex_RegWrite, ex_MemRead, ex_branch_taken;
  logic mem_RegWrite, mem_req, dmem_ready, wb_RegWrite;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, dmem_err;
  logic [1:0] fwd_a, fwd_b, dbg_state;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_A3(ex_A3), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_A3(mem_A3), .mem_RegWrite(mem_RegWrite), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .wb_A3(wb_A3), .wb_RegWrite(wb_RegWrite),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_err(dmem_err), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic quiet();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_A3 = 0; ex_RegWrite = 0; ex_MemRead = 0;
    ex_branch_taken = 0; mem_A3 = 0; mem_RegWrite = 0; mem_req = 0;
    dmem_ready = 0; wb_A3 = 0; wb_RegWrite = 0;
  endtask

  task automatic randomize_inputs();
    id_rs = 5'($urandom_range(0, 31)); id_rt = 5'($urandom_range(0, 31));
    id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
    ex_rs = 5'($urandom_range(0, 31)); ex_rt = 5'($urandom_range(0, 31));
    ex_A3 = 5'($urandom_range(0, 31)); ex_RegWrite = 1'($urandom_range(0, 1));
    ex_MemRead = 1'($urandom_range(0, 1)); ex_branch_taken = 1'($urandom_range(0, 1));
    mem_A3 = 5'($urandom_range(0, 31)); mem_RegWrite = 1'($urandom_range(0, 1));
    mem_req = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
    wb_A3 = 5'($urandom_range(0, 31)); wb_RegWrite = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pc,ifid,idex,exmem,memwb} enables
  function automatic logic [4:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [2:0] fls();
    return {ifid_flush, idex_flush, memwb_flush};
  endfunction

  task automatic set_loaduse_rs(input logic [4:0] r);
    quiet();
    ex_MemRead = 1; ex_RegWrite = 1; ex_A3 = r; id_rs = r; id_uses_rs = 1;
  endtask

  initial begin
    quiet();
    rst = 1;
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      #1;
      check("rst_en", ens(), 5'b00000);
      check("rst_flush", fls(), 3'b000);
      check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
      check("rst_err", dmem_err, 0);
      tick();
    end
    check("rst_cnt", stall_cnt, 0);
    check("rst_state", dbg_state, 0);

    rst = 0;
    quiet();
    #1;
    check("quiet_en", ens(), 5'b11111);
    check("quiet_flush", fls(), 3'b000);
    tick();

    // load-use on rs
    set_loaduse_rs(5);
    #1;
    check("lu_en", ens(), 5'b00111);
    check("lu_flush", fls(), 3'b010);
    tick();
    quiet();
    #1;
    check("lu_after_pc", pc_en, 1);
    check("lu_cnt", stall_cnt, 1);

    // load-use on $0 is not a hazard
    quiet();
    ex_MemRead = 1; ex_A3 = 0; id_rs = 0; id_uses_rs = 1;
    #1;
    check("lu_zero_en", ens(), 5'b11111);

    // branch plus load-use
    set_loaduse_rs(9);
    ex_branch_taken = 1;
    #1;
    check("br_en", ens(), 5'b11111);
    check("br_flush", fls(), 3'b110);
    tick();
    quiet();
    #1;
    check("br_cnt", stall_cnt, 1);

    // forwarding
    ex_rs = 3; ex_rt = 0; mem_A3 = 3; wb_A3 = 3; mem_RegWrite = 1; wb_RegWrite = 1;
    #1;
    check("fwd_a_mem", fwd_a, 2'b10);
    check("fwd_b_zero", fwd_b, 2'b00);
    mem_A3 = 0;
    ex_rt = 3;
    #1;
    check("fwd_a_wb", fwd_a, 2'b01);
    check("fwd_b_wb", fwd_b, 2'b01);
    wb_RegWrite = 0;
    #1;
    check("fwd_a_rf", fwd_a, 2'b00);
    mem_A3 = 3; ex_rs = 4;
    #1;
    check("fwd_b_mem", fwd_b, 2'b10);
    check("fwd_a_nomatch", fwd_a, 2'b00);
    quiet();

    // access completes on first cycle
    mem_req = 1; dmem_ready = 1;
    #1;
    check("mem1_en", ens(), 5'b11111);
    tick();
    check("mem1_state", dbg_state, 0);

    // memory wait 3 cycles, with a load-use that must be ignored
    set_loaduse_rs(6);
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_en", ens(), 5'b00001);
      check("mw_flush", fls(), 3'b001);
      tick();
      check("mw_state", dbg_state, 1);
    end
    quiet();
    mem_req = 1; dmem_ready = 1;
    #1;
    check("mw_done_en", ens(), 5'b11111);
    tick();
    check("mw_back_state", dbg_state, 0);
    check("mw_cnt", stall_cnt, 4);

    // back-to-back load-use
    set_loaduse_rs(5);
    #1;
    check("b2b1_flush", fls(), 3'b010);
    check("b2b1_pc", pc_en, 0);
    tick();
    quiet();
    ex_MemRead = 1; ex_A3 = 7; id_rt = 7; id_uses_rt = 1;
    #1;
    check("b2b2_flush", fls(), 3'b010);
    check("b2b2_pc", pc_en, 0);
    tick();
    quiet();
    #1;
    check("b2b_cnt", stall_cnt, 6);

    // watchdog
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    check("wd_early_err", dmem_err, 0);
    check("wd_early_cnt", stall_cnt, 10);
    for (int i = 0; i < 4; i++) tick();
    check("wd_err", dmem_err, 1);
    check("wd_state", dbg_state, 2);
    check("wd_cnt", stall_cnt, 14);
    quiet();
    #1;
    check("err_en", ens(), 5'b00000);
    check("err_flush", fls(), 3'b000);
    tick();
    tick();
    check("err_sticky", dmem_err, 1);
    check("cnt_sat", stall_cnt, 15);

    rst = 1;
    #1;
    check("rst2_err", dmem_err, 0);
    check("rst2_en", ens(), 5'b00000);
    tick();
    rst = 0;
    #1;
    check("rst2_state", dbg_state, 0);
    check("rst2_cnt", stall_cnt, 0);
    check("rst2_err_after", dmem_err, 0);
    check("rst2_en_after", ens(), 5'b11111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush/forwarding controller for the 5-stage MIPS pipeline. Watches register addresses and control bits in ID, EX, MEM and WB, plus the data-memory handshake. Drives the enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and the EX-stage forwarding muxes. Includes a memory-wait watchdog and a stall-cycle performance counter.

## Interface
- WAIT_MAX, 16: max consecutive cycles MEM may wait on dmem_ready before error
- CNT_W, 16: width of stall-cycle counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source regs of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- ex_rs, ex_rt  in  5 each  source regs of instruction in EX
- ex_A3  in  5  dest reg in EX
- ex_RegWrite, ex_MemRead  in  1 each  EX writes reg / EX is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_A3  in  5  dest reg in MEM
- mem_RegWrite  in  1  MEM writes reg
- mem_req  in  1  MEM stage accesses data memory this cycle
- dmem_ready  in  1  data memory completes access this cycle
- wb_A3  in  5  dest reg in WB
- wb_RegWrite  in  1  WB writes reg
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all-zero control)
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- dmem_err  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- FSM states: RUN, MEMWAIT, ERR. State register changes on clk only.
- Define memstall = mem_req & ~dmem_ready.
- Define loaduse = ex_MemRead & ex_A3!=0 & ((id_uses_rs & id_rs==ex_A3) | (id_uses_rt & id_rt==ex_A3)).
- Priority per cycle: ERR > memstall > branch > loaduse > normal.
- ERR:
  - all *_en=0, all flushes=0, dmem_err=1.
  - Exits only on rst.
- memstall (RUN or MEMWAIT):
  - pc_en/ifid_en/idex_en/exmem_en=0.
  - memwb_en=1 with memwb_flush=1, so WB retires and a bubble enters MEM/WB.
  - Branch and loaduse are ignored this cycle; they re-evaluate after the stall because the instructions are held.
- branch (ex_branch_taken, no memstall):
  - all en=1, ifid_flush=1, idex_flush=1.
  - Overrides loaduse, since the ID instruction is squashed.
- loaduse (no memstall, no branch):
  - pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1; exmem_en and memwb_en=1.
  - Exactly one bubble per hazard.
- normal: all en=1, all flush=0.
- Forwarding, per operand, for ex_rs→fwd_a and ex_rt→fwd_b:
  - 10 if mem_RegWrite & mem_A3!=0 & mem_A3==src;
  - else 01 if wb_RegWrite & wb_A3!=0 & wb_A3==src;
  - else 00.
  - EX/MEM has priority. $0 is never forwarded.
  - Forwarding is independent of the stall state.
- Watchdog wait counter (width clog2(WAIT_MAX+1)):
  - Cleared in RUN.
  - Increments each MEMWAIT cycle with memstall.
  - When count reaches WAIT_MAX with memstall still high, next state is ERR.
- Transitions:
  - RUN→MEMWAIT when memstall.
  - MEMWAIT→RUN when dmem_ready or ~mem_req.
  - MEMWAIT→ERR on watchdog expiry.
- stall_cnt increments by 1 on each cycle with pc_en=0 (excluding rst) and saturates at all-ones.

## Timing
- All enables, flushes and fwd_* are combinational from current inputs and state. Zero-cycle latency: they take effect at the same clk edge.
- State, wait counter, dmem_err and stall_cnt are registered, updating one cycle after the causing inputs.
- While rst=1:
  - all *_en=0, flushes=0, fwd_a=fwd_b=00, dmem_err=0.
  - Next state RUN; wait counter and stall_cnt cleared.
- Reset asserted mid-MEMWAIT or in ERR returns to RUN on the next edge.
- A memory access completing on its first cycle (dmem_ready=1 with mem_req) causes no stall and no state change.
- Load-use followed by another load-use on the next ID instruction produces back-to-back single bubbles.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - FSM state enum (RUN, MEMWAIT, ERR).
  - forwarding select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module is natural: `fwd_unit`, purely combinational, instantiated once and producing fwd_a/fwd_b.
- FSM, watchdog and counter stay in the top.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all en=0, dmem_err=0, stall_cnt=0. The first cycle after reset with quiet inputs → all en=1.
- Load-use: ex_MemRead=1, ex_A3=5, id_rs=5, id_uses_rs=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1 afterwards.
- Branch plus load-use in the same cycle → ifid_flush=idex_flush=1, pc_en=1, no stall counted.
- Forwarding: ex_rs=3 with mem_A3=wb_A3=3 and both RegWrite → fwd_a=10. With mem_A3=0 → fwd_a=01. With ex_rt=0 → fwd_b=00.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 → 3 cycles with upstream en=0 and memwb_flush=1, state returns to RUN, stall_cnt=3.
- Watchdog: WAIT_MAX=4, dmem_ready held 0 → ERR entered after the limit, dmem_err=1 sticky. A later rst pulse clears it.
